// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse stretcher slice.
package pulse_pkg;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;
endpackage

// File: rtl/pulse_stretcher_if.sv
// Control-side bundle of the pulse stretcher: trigger/config in, stretched level and status out.
interface pulse_stretcher_if
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             trig;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] gap;
  logic             retrig_en;
  logic             level_out;
  logic             busy;
  logic             done;
  logic             dropped;

  modport master (
    output trig, len, gap, retrig_en,
    input  level_out, busy, done, dropped
  );

  modport slave (
    input  trig, len, gap, retrig_en,
    output level_out, busy, done, dropped
  );
endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter shared by the HIGH and GAP phases; flags a value of one.
module load_down_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Decrement only from two or more, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q > CNT_W'(1)))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into a high level of programmable length plus an optional low holdoff.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_stretcher_if.slave  bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;
  logic             load, dec, is_one;
  logic [CNT_W-1:0] load_val;

  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_val_i (load_val),
    .dec_i      (dec),
    .is_one_o   (is_one)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    load      = 1'b0;
    load_val  = bus.len;
    dec       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.trig) begin
          if (bus.len != '0) begin
            load    = 1'b1;
            gap_d   = bus.gap;
            state_d = HIGH;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      HIGH: begin
        // An accepted reload takes priority over the final-cycle exit.
        if (bus.trig && bus.retrig_en && (bus.len != '0)) begin
          load = 1'b1;
        end else begin
          dropped_d = bus.trig;
          if (is_one) begin
            done_d = 1'b1;
            if (gap_q != '0) begin
              load     = 1'b1;
              load_val = gap_q;
              state_d  = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dec = 1'b1;
          end
        end
      end
      GAP: begin
        dropped_d = bus.trig;
        if (is_one) state_d = IDLE;
        else        dec     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.level_out = (state_q == HIGH);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.dropped   = dropped_q;
endmodule
